// File: rtl/t01_drop_scheduler.sv
// Gravity sequencer for the active t01 piece: spawn handshake, timed drop ticks,
// lock delay, hard drop and the final lock pulse.
module t01_drop_scheduler #(
    parameter logic [24:0] BASE_INTERVAL = 25'd25_000_000,
    parameter logic [24:0] MIN_INTERVAL  = 25'd2_000_000,
    parameter logic [24:0] SOFT_INTERVAL = 25'd1_000_000,
    parameter logic [24:0] LOCK_DELAY    = 25'd12_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_active,
    input  logic        pause,
    input  logic [24:0] scoremod,
    input  logic        soft_drop,
    input  logic        hard_drop,
    input  logic        collision_below,
    input  logic        spawn_done,
    output logic        drop_tick,
    output logic        lock_piece,
    output logic        spawn_req,
    output logic [2:0]  state,
    output logic [24:0] interval
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPAWN    = 3'd1,
        FALL     = 3'd2,
        LOCKWAIT = 3'd3,
        LOCK     = 3'd4
    } state_t;

    localparam logic [24:0] CLAMP_POINT = BASE_INTERVAL - MIN_INTERVAL;

    state_t      cur_state;
    logic [24:0] fall_cnt;
    logic [24:0] lock_cnt;
    logic        hard_flag;
    logic        drop_pend;
    logic        lock_pend;
    logic [24:0] gravity;
    logic [24:0] next_interval;
    logic        fall_due;
    logic        lock_due;

    always_comb begin
        gravity       = (scoremod >= CLAMP_POINT) ? MIN_INTERVAL : (BASE_INTERVAL - scoremod);
        next_interval = (soft_drop && (gravity > SOFT_INTERVAL)) ? SOFT_INTERVAL : gravity;
    end

    // Compared with +1 in 26 bits so a small interval can never underflow.
    assign fall_due = ({1'b0, fall_cnt} + 26'd1) >= {1'b0, interval};
    assign lock_due = ({1'b0, lock_cnt} + 26'd1) >= {1'b0, LOCK_DELAY};

    // Pulses are held through a pause and only masked here, so a pending
    // lock or drop appears on the first unpaused cycle.
    assign drop_tick  = drop_pend & ~pause;
    assign lock_piece = lock_pend & ~pause;
    assign state      = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            fall_cnt  <= '0;
            lock_cnt  <= '0;
            hard_flag <= 1'b0;
            drop_pend <= 1'b0;
            lock_pend <= 1'b0;
            spawn_req <= 1'b0;
            interval  <= BASE_INTERVAL;
        end else begin
            interval <= next_interval;
            if (!game_active) begin
                cur_state <= IDLE;
                fall_cnt  <= '0;
                lock_cnt  <= '0;
                hard_flag <= 1'b0;
                drop_pend <= 1'b0;
                lock_pend <= 1'b0;
                spawn_req <= 1'b0;
            end else if (!pause) begin
                drop_pend <= 1'b0;
                lock_pend <= 1'b0;
                case (cur_state)
                    IDLE: begin
                        cur_state <= SPAWN;
                        spawn_req <= 1'b1;
                    end
                    SPAWN: begin
                        if (spawn_done) begin
                            cur_state <= FALL;
                            spawn_req <= 1'b0;
                            fall_cnt  <= '0;
                        end
                    end
                    FALL: begin
                        // Hard drop alternates pulse/gap; collision is only trusted after a gap.
                        if (hard_flag || hard_drop) begin
                            hard_flag <= 1'b1;
                            if (collision_below && !(hard_flag && drop_pend)) begin
                                cur_state <= LOCK;
                                lock_pend <= 1'b1;
                            end else if (!drop_pend) begin
                                drop_pend <= 1'b1;
                            end
                        end else if (fall_due) begin
                            fall_cnt <= '0;
                            if (collision_below) begin
                                cur_state <= LOCKWAIT;
                                lock_cnt  <= '0;
                            end else begin
                                drop_pend <= 1'b1;
                            end
                        end else begin
                            fall_cnt <= fall_cnt + 25'd1;
                        end
                    end
                    LOCKWAIT: begin
                        if (hard_drop) begin
                            cur_state <= LOCK;
                            lock_pend <= 1'b1;
                            lock_cnt  <= '0;
                        end else if (!collision_below) begin
                            cur_state <= FALL;
                            fall_cnt  <= '0;
                            lock_cnt  <= '0;
                        end else if (lock_due) begin
                            cur_state <= LOCK;
                            lock_pend <= 1'b1;
                            lock_cnt  <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 25'd1;
                        end
                    end
                    LOCK: begin
                        cur_state <= SPAWN;
                        spawn_req <= 1'b1;
                        hard_flag <= 1'b0;
                        fall_cnt  <= '0;
                    end
                    default: begin
                        cur_state <= IDLE;
                        spawn_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t01_drop_scheduler.sv
// Self-checking bench for t01_drop_scheduler using shortened timing constants
// (BASE=20, MIN=4, SOFT=2, LOCK=5).
module tb_t01_drop_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_active;
    logic        pause;
    logic [24:0] scoremod;
    logic        soft_drop;
    logic        hard_drop;
    logic        collision_below;
    logic        spawn_done;
    logic        drop_tick;
    logic        lock_piece;
    logic        spawn_req;
    logic [2:0]  state;
    logic [24:0] interval;

    typedef struct {
        logic [24:0] sm;
        logic        sd;
        logic [24:0] exp_int;
    } vec_t;

    vec_t vecs[10];
    bit   hard_pat[6];
    int   compared   = 0;
    int   mismatched = 0;
    int   exp_q[$];
    int   drops;

    t01_drop_scheduler #(
        .BASE_INTERVAL(25'd20),
        .MIN_INTERVAL (25'd4),
        .SOFT_INTERVAL(25'd2),
        .LOCK_DELAY   (25'd5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .game_active    (game_active),
        .pause          (pause),
        .scoremod       (scoremod),
        .soft_drop      (soft_drop),
        .hard_drop      (hard_drop),
        .collision_below(collision_below),
        .spawn_done     (spawn_done),
        .drop_tick      (drop_tick),
        .lock_piece     (lock_piece),
        .spawn_req      (spawn_req),
        .state          (state),
        .interval       (interval)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        scoremod  = v.sm;
        soft_drop = v.sd;
        @(negedge clk);
    endtask

    // Counts cycles from the current negedge to the next visible drop_tick.
    task automatic waitTick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (drop_tick !== 1'b1 && n < 100);
    endtask

    task automatic checkGap(input string name);
        int n;
        int e;
        waitTick(n);
        if (exp_q.size() == 0) e = -1;
        else e = exp_q.pop_front();
        checkOutput(name, 32'(n), 32'(e));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{25'd0,        1'b0, 25'd20};
        vecs[1] = '{25'd10,       1'b0, 25'd10};
        vecs[2] = '{25'd15,       1'b0, 25'd5};
        vecs[3] = '{25'd16,       1'b0, 25'd4};
        vecs[4] = '{25'd17,       1'b0, 25'd4};
        vecs[5] = '{25'd100,      1'b0, 25'd4};
        vecs[6] = '{25'h1FFFFFF,  1'b0, 25'd4};
        vecs[7] = '{25'd0,        1'b1, 25'd2};
        vecs[8] = '{25'd18,       1'b1, 25'd2};
        vecs[9] = '{25'd3,        1'b0, 25'd17};
        hard_pat[0] = 1'b1; hard_pat[1] = 1'b0; hard_pat[2] = 1'b1;
        hard_pat[3] = 1'b0; hard_pat[4] = 1'b1; hard_pat[5] = 1'b0;

        reset = 1'b1; game_active = 1'b0; pause = 1'b0; scoremod = '0;
        soft_drop = 1'b0; hard_drop = 1'b0; collision_below = 1'b0; spawn_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_drop", 32'(drop_tick), 32'd0);
        checkOutput("reset_lock", 32'(lock_piece), 32'd0);
        checkOutput("reset_spawn", 32'(spawn_req), 32'd0);
        checkOutput("reset_interval", 32'(interval), 32'd20);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("interval_vec%0d", i), 32'(interval), 32'(vecs[i].exp_int));
        end
        checkOutput("idle_inactive", 32'(state), 32'd0);

        // Spawn handshake and base gravity
        scoremod = '0; soft_drop = 1'b0;
        @(negedge clk);
        game_active = 1'b1;
        @(negedge clk);
        checkOutput("spawn_state", 32'(state), 32'd1);
        checkOutput("spawn_req_on", 32'(spawn_req), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("spawn_req_hold", 32'(spawn_req), 32'd1);
        spawn_done = 1'b1;
        @(negedge clk);
        spawn_done = 1'b0;
        checkOutput("fall_state", 32'(state), 32'd2);
        checkOutput("spawn_req_off", 32'(spawn_req), 32'd0);
        exp_q.push_back(20); checkGap("gap_base0");
        exp_q.push_back(20); checkGap("gap_base1");
        checkOutput("interval_base", 32'(interval), 32'd20);

        scoremod = 25'd10;
        exp_q.push_back(10); checkGap("gap_sm10_0");
        exp_q.push_back(10); checkGap("gap_sm10_1");
        scoremod = 25'd100;
        exp_q.push_back(4); checkGap("gap_clamp0");
        exp_q.push_back(4); checkGap("gap_clamp1");
        soft_drop = 1'b1;
        exp_q.push_back(2); checkGap("gap_soft0");
        exp_q.push_back(2); checkGap("gap_soft1");
        exp_q.push_back(2); checkGap("gap_soft2");
        checkOutput("interval_soft", 32'(interval), 32'd2);
        soft_drop = 1'b0;
        exp_q.push_back(4); checkGap("gap_soft_release");
        checkOutput("interval_release", 32'(interval), 32'd4);
        scoremod = 25'd0;
        exp_q.push_back(20); checkGap("gap_back_to_base");
        repeat (12) @(negedge clk);
        scoremod = 25'd100;
        exp_q.push_back(2); checkGap("gap_shrink_below_count");

        // Collision at a tick, then lock delay
        scoremod = 25'd0; collision_below = 1'b1; drops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drop_tick) drops++;
        end
        checkOutput("collide_no_drop", 32'(drops), 32'd0);
        checkOutput("lockwait_state", 32'(state), 32'd3);
        repeat (4) @(negedge clk);
        checkOutput("lockwait_still", 32'(state), 32'd3);
        checkOutput("lockwait_no_lock", 32'(lock_piece), 32'd0);
        @(negedge clk);
        checkOutput("lock_state", 32'(state), 32'd4);
        checkOutput("lock_pulse", 32'(lock_piece), 32'd1);
        checkOutput("lock_no_drop", 32'(drop_tick), 32'd0);
        @(negedge clk);
        checkOutput("respawn_state", 32'(state), 32'd1);
        checkOutput("lock_one_cycle", 32'(lock_piece), 32'd0);
        checkOutput("respawn_req", 32'(spawn_req), 32'd1);

        // Piece slides off a ledge during lock delay
        spawn_done = 1'b1;
        @(negedge clk);
        spawn_done = 1'b0;
        checkOutput("slide_fall", 32'(state), 32'd2);
        repeat (20) @(negedge clk);
        checkOutput("slide_lockwait", 32'(state), 32'd3);
        collision_below = 1'b0;
        @(negedge clk);
        checkOutput("slide_back_fall", 32'(state), 32'd2);
        exp_q.push_back(20); checkGap("gap_after_slide");

        // Hard drop: pulse/gap pattern, collision after the third pulse
        @(negedge clk);
        hard_drop = 1'b1;
        @(negedge clk);
        hard_drop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("hard_pat%0d", i), 32'(drop_tick), 32'(hard_pat[i]));
            if (i == 4) collision_below = 1'b1;
        end
        @(negedge clk);
        checkOutput("hard_lock_state", 32'(state), 32'd4);
        checkOutput("hard_lock_pulse", 32'(lock_piece), 32'd1);

        // Hard drop during SPAWN is discarded; grounded hard drop locks at once
        @(negedge clk);
        checkOutput("hard_respawn", 32'(state), 32'd1);
        hard_drop = 1'b1;
        @(negedge clk);
        hard_drop = 1'b0;
        checkOutput("hard_in_spawn_ignored", 32'(state), 32'd1);
        spawn_done = 1'b1; collision_below = 1'b0;
        @(negedge clk);
        spawn_done = 1'b0;
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (drop_tick) drops++;
        end
        checkOutput("hard_discard_no_drop", 32'(drops), 32'd0);
        collision_below = 1'b1; hard_drop = 1'b1;
        @(negedge clk);
        hard_drop = 1'b0;
        checkOutput("hard_grounded_lock", 32'(state), 32'd4);
        checkOutput("hard_grounded_pulse", 32'(lock_piece), 32'd1);
        @(negedge clk);

        // Pause mid-FALL at count 12 for 7 cycles
        collision_below = 1'b0; spawn_done = 1'b1;
        @(negedge clk);
        spawn_done = 1'b0;
        checkOutput("pause_fall_entry", 32'(state), 32'd2);
        repeat (12) @(negedge clk);
        pause = 1'b1;
        drops = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (drop_tick) drops++;
        end
        checkOutput("pause_no_drop", 32'(drops), 32'd0);
        checkOutput("pause_hold_state", 32'(state), 32'd2);
        pause = 1'b0;
        exp_q.push_back(8); checkGap("gap_after_pause");

        // Pause while in LOCK delays the lock pulse
        @(negedge clk);
        collision_below = 1'b1; hard_drop = 1'b1;
        @(negedge clk);
        hard_drop = 1'b0; pause = 1'b1;
        #1;
        checkOutput("pause_lock_state", 32'(state), 32'd4);
        checkOutput("pause_lock_masked", 32'(lock_piece), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("pause_lock_hold", 32'(state), 32'd4);
        checkOutput("pause_lock_masked2", 32'(lock_piece), 32'd0);
        pause = 1'b0;
        #1;
        checkOutput("unpause_lock_pulse", 32'(lock_piece), 32'd1);
        @(negedge clk);
        checkOutput("unpause_spawn", 32'(state), 32'd1);
        checkOutput("unpause_lock_done", 32'(lock_piece), 32'd0);

        // spawn_done ignored while paused
        pause = 1'b1; spawn_done = 1'b1;
        @(negedge clk);
        checkOutput("pause_spawn_hold", 32'(state), 32'd1);
        checkOutput("pause_spawn_req", 32'(spawn_req), 32'd1);
        spawn_done = 1'b0; pause = 1'b0;
        @(negedge clk);
        checkOutput("spawn_after_pause", 32'(state), 32'd1);

        // Asynchronous reset in LOCKWAIT
        scoremod = 25'd10; spawn_done = 1'b1;
        @(negedge clk);
        spawn_done = 1'b0;
        checkOutput("interval_before_reset", 32'(interval), 32'd10);
        repeat (12) @(negedge clk);
        checkOutput("lockwait_before_reset", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_state", 32'(state), 32'd0);
        checkOutput("async_reset_interval", 32'(interval), 32'd20);
        checkOutput("async_reset_spawn", 32'(spawn_req), 32'd0);
        checkOutput("async_reset_lock", 32'(lock_piece), 32'd0);
        @(negedge clk);
        reset = 1'b0; collision_below = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_spawn", 32'(state), 32'd1);

        // game_active dropped in FALL
        spawn_done = 1'b1;
        @(negedge clk);
        spawn_done = 1'b0;
        repeat (3) @(negedge clk);
        game_active = 1'b0;
        @(negedge clk);
        checkOutput("inactive_idle", 32'(state), 32'd0);
        drops = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (drop_tick) drops++;
        end
        checkOutput("inactive_no_drop", 32'(drops), 32'd0);
        checkOutput("inactive_spawn_req", 32'(spawn_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/t01_drop_scheduler.md
Name: t01_drop_scheduler

Overview:
- Sequences the active piece's gravity for the t01 game: spawn request, timed drop ticks, lock delay, lock pulse.
- Drop interval shortens as the speed controller's scoremod output rises. Floored at MIN_INTERVAL; soft drop can shorten it further.
- Sits between the speed controller (scoremod) and the piece datapath, which consumes drop_tick, lock_piece and spawn_req, and returns collision_below and spawn_done.

Parameters:
- BASE_INTERVAL, 25'd25_000_000, drop period in cycles at scoremod = 0.
- MIN_INTERVAL, 25'd2_000_000, floor on the gravity interval.
- SOFT_INTERVAL, 25'd1_000_000, interval while soft_drop is held.
- LOCK_DELAY, 25'd12_500_000, cycles a grounded piece waits before locking.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high.
- game_active, input, 1, game running; 0 forces IDLE.
- pause, input, 1, freezes scheduler.
- scoremod, input, 25, interval reduction from the speed controller.
- soft_drop, input, 1, level; fast gravity.
- hard_drop, input, 1, pulse; drop to floor and lock.
- collision_below, input, 1, piece cannot move down one row.
- spawn_done, input, 1, pulse; datapath has placed a new piece.
- drop_tick, output, 1, one-cycle pulse; move piece down one row.
- lock_piece, output, 1, one-cycle pulse; commit piece to board.
- spawn_req, output, 1, level; request new piece.
- state, output, 3, IDLE=0, SPAWN=1, FALL=2, LOCKWAIT=3, LOCK=4.
- interval, output, 25, current effective gravity interval (registered).

Behaviour:
- Reset, asynchronous: state=IDLE, fall/lock counters=0, hard flag=0, all pulse outputs 0, spawn_req=0, interval=BASE_INTERVAL.
- Priority per cycle: reset > !game_active > pause > hard_drop > timers.
- Gravity interval g:
  - g = MIN_INTERVAL if scoremod >= BASE_INTERVAL-MIN_INTERVAL, else g = BASE_INTERVAL-scoremod.
  - Compare is full 25-bit unsigned; no wrap.
- Effective interval: interval = min(g, SOFT_INTERVAL) when soft_drop=1, else g. Registered every cycle.
- Fall counter:
  - Increments in FALL.
  - Tick when counter >= interval-1; counter then clears to 0.
  - If the interval shrinks below the current count, the tick fires on the next FALL cycle.
- !game_active in any state: next state IDLE, counters and hard flag cleared, outputs 0.
- IDLE: game_active=1 -> SPAWN.
- SPAWN:
  - spawn_req=1 (registered, asserted the first cycle in SPAWN).
  - spawn_done -> FALL with fall counter=0.
  - Inputs other than game_active are ignored.
- FALL:
  - On tick with collision_below=0: drop_tick=1 for one cycle.
  - On tick with collision_below=1: no drop_tick; -> LOCKWAIT, lock counter=0.
- Hard drop (hard_drop in FALL sets hard flag):
  - While the flag is set, the timer is ignored.
  - drop_tick pulses on alternate cycles (pulse, gap) while collision_below=0, so the datapath has a cycle to update collision_below.
  - In the first cycle after a gap with collision_below=1 -> LOCK.
  - If collision_below=1 when hard_drop arrives -> LOCK next cycle.
- LOCKWAIT:
  - Lock counter increments.
  - collision_below=0 (piece slid off a ledge) -> FALL with fall counter=0, lock counter=0.
  - Counter reaches LOCK_DELAY-1 -> LOCK.
  - hard_drop -> LOCK next cycle.
- LOCK: lock_piece=1 for exactly one cycle; hard flag cleared; -> SPAWN.
- pause=1:
  - State, counters and hard flag hold.
  - drop_tick and lock_piece are forced 0; spawn_req holds its value.
  - spawn_done is ignored.
  - A LOCK held by pause emits its pulse on the first unpaused cycle.
- hard_drop during pause, SPAWN or IDLE is discarded.
- drop_tick and lock_piece never assert in the same cycle; drop_tick never asserts outside FALL.

Test Plan (BASE=20, MIN=4, SOFT=2, LOCK=5):
- Reset, game_active=1, spawn_done pulse, scoremod=0 -> spawn_req high until spawn_done; then drop_tick every 20 cycles; interval=20.
- scoremod=10 -> interval=10, ticks every 10; scoremod=100 -> interval=4 (clamp); soft_drop=1 -> interval=2, ticks every 2; release soft_drop -> back to 4.
- collision_below=1 at a tick -> no drop_tick, state=3; 5 cycles later lock_piece one cycle, state=4, then spawn_req=1; collision_below dropped during LOCKWAIT instead -> state=2, next tick 20 cycles later.
- hard_drop in FALL, collision_below rising after 3 drop_ticks -> drop_ticks on alternate cycles; lock_piece 2 cycles after 3rd tick.
- pause for 7 cycles mid-FALL at count 12 -> no pulses; tick 8 cycles after unpause; pause in LOCK delays lock_piece to the first unpaused cycle.
- reset asserted mid-LOCKWAIT -> outputs 0 and state=0 immediately (asynchronous); game_active=0 in FALL -> IDLE next cycle, no further ticks.
